booth_ctrl: RTL and testbench
=============================

Name: booth_ctrl

Overview:
- FSM controller that sequences the radix-2 Booth multiplier datapath (X, Y, A shift registers, Y-1 flag register, add/sub unit, two tri-state drivers onto the shared output bus).
- Loads multiplicand and multiplier from the shared input bus and runs N add/sub-and-shift iterations.
- Drives the 2N-bit product onto the output bus, high word first, then low word.
- Sits between the system handshake (start/ready/done) and the datapath control pins.

Parameters:
- N, 6, operand width. Also sets the iteration count and the counter width of ceil(log2(N+1)) bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiplication; sampled only in IDLE
- Y0YminusOne  input  2  {Y[0], Y-1} from the datapath
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse in OUT_LO
- ldX  output  1  load X from inBus
- ldY  output  1  load Y from inBus
- ldA  output  1  load A from adder result
- initA  output  1  clear A
- initYminusOne  output  1  clear Y-1
- aBarS  output  1  adder mode: 0 = A+X, 1 = A−X
- shRA  output  1  arithmetic right shift of A; A[0] shifts into Y
- shRY  output  1  right shift of Y
- ldYminusOne  output  1  capture Y[0] into Y-1
- selL  output  1  drive A (high word) onto outBus
- selR  output  1  drive Y (low word) onto outBus

Behaviour:
- Reset: state = IDLE, counter = 0. All control outputs and done are 0; ready = 1. Reset mid-operation aborts immediately; no bus driver stays enabled.
- Control outputs are decoded from the state. ldA and aBarS in CHECK also depend on Y0YminusOne. Any output not listed for a state is 0.
- IDLE: ready = 1.
  - start = 1 → LOAD_X.
  - start = 0 → stay in IDLE.
- LOAD_X: ldX = 1. The environment presents X on inBus during this cycle. → LOAD_Y.
- LOAD_Y: ldY = 1, initA = 1, initYminusOne = 1. The environment presents Y on inBus. Counter cleared to 0. → CHECK.
- CHECK: decode Y0YminusOne:
  - 2'b01: ldA = 1, aBarS = 0 (add).
  - 2'b10: ldA = 1, aBarS = 1 (subtract).
  - 2'b00 or 2'b11: no load.
  - → SHIFT in all cases.
- SHIFT: shRA = 1, shRY = 1, ldYminusOne = 1, all asserted together so Y-1 captures the pre-shift Y[0]. Counter increments.
  - New counter value == N → OUT_HI.
  - Otherwise → CHECK.
- OUT_HI: selL = 1. → OUT_LO.
- OUT_LO: selR = 1, done = 1. → IDLE.
- selL and selR are never asserted in the same cycle.
- start is ignored outside IDLE; a start held high through OUT_LO begins a new operation on the cycle after return to IDLE.
- Latency: start sampled at cycle 0, LOAD_X at cycle 1, high word at cycle 2N+3, low word and done at cycle 2N+4 (16 for N = 6). Throughput is one product per 2N+5 cycles.
- Counter never wraps; it is compared against N only in SHIFT.
- Operands are two's complement; the product is signed 2N-bit {A, Y}. The most-negative × most-negative case is exact (no overflow for 2N bits).

Optional Feature:
- Macro: BOOTH_SKIP_ADD_EN.
- Defined: in CHECK, when Y0YminusOne is 2'b00 or 2'b11, the controller asserts the SHIFT outputs (shRA, shRY, ldYminusOne, counter increment) in CHECK itself.
  - It then goes to CHECK, or to OUT_HI if the counter reaches N; SHIFT is skipped.
  - Each no-op iteration costs 1 cycle instead of 2.
  - done cycle = N + (number of add/sub iterations) + 4.
- Undefined: fixed 2N+4 latency as above.

Test Plan:
- Reset, then idle 3 cycles → ready = 1; all control outputs = 0.
- X = 5, Y = 3 → outBus 6'b000000 with selL at cycle 15, then 6'b001111 with selR and done at cycle 16. With BOOTH_SKIP_ADD_EN: done at cycle 12.
- X = −3 (6'b111101), Y = 5 → product −15: hi 6'b111111, lo 6'b110001. In CHECK, aBarS = 1 on iterations 0, 2 and aBarS = 0 on iterations 1, 3.
- X = −32, Y = −32 → hi 6'b010000, lo 6'b000000. X = 0, Y = 6'b101010 → product 0.
- Pulse start in iteration 3 of an operation → ignored; the running operation completes with exactly one done pulse.
- Assert rst in SHIFT of iteration 2 → next cycle IDLE, ready = 1, selL = selR = 0. A fresh start then yields a correct product (7 × 7 = 49: hi 0, lo 6'b110001).

Source files
------------

// File: rtl/booth_ctrl.sv
// booth_ctrl: radix-2 Booth multiplier sequencer (load X/Y, N add/sub-and-shift steps, two-word output).
// Optional macro BOOTH_SKIP_ADD_EN folds no-op iterations into a single CHECK cycle.
`default_nettype none

module booth_ctrl #(
   parameter int N = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] Y0YminusOne,
   output logic       ready,
   output logic       done,
   output logic       ldX,
   output logic       ldY,
   output logic       ldA,
   output logic       initA,
   output logic       initYminusOne,
   output logic       aBarS,
   output logic       shRA,
   output logic       shRY,
   output logic       ldYminusOne,
   output logic       selL,
   output logic       selR
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_X = 3'd1;
   localparam logic [2:0] S_LOAD_Y = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_SHIFT  = 3'd4;
   localparam logic [2:0] S_OUT_HI = 3'd5;
   localparam logic [2:0] S_OUT_LO = 3'd6;

   logic [2:0]    state, state_nxt;
   logic [CW-1:0] count, count_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      ready         = 1'b0;
      done          = 1'b0;
      ldX           = 1'b0;
      ldY           = 1'b0;
      ldA           = 1'b0;
      initA         = 1'b0;
      initYminusOne = 1'b0;
      aBarS         = 1'b0;
      shRA          = 1'b0;
      shRY          = 1'b0;
      ldYminusOne   = 1'b0;
      selL          = 1'b0;
      selR          = 1'b0;
      case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = S_LOAD_X;
         end
         S_LOAD_X: begin
            ldX       = 1'b1;
            state_nxt = S_LOAD_Y;
         end
         S_LOAD_Y: begin
            ldY           = 1'b1;
            initA         = 1'b1;
            initYminusOne = 1'b1;
            count_nxt     = '0;
            state_nxt     = S_CHECK;
         end
         S_CHECK: begin
            case (Y0YminusOne)
               2'b01: begin
                  ldA       = 1'b1;
                  state_nxt = S_SHIFT;
               end
               2'b10: begin
                  ldA       = 1'b1;
                  aBarS     = 1'b1;
                  state_nxt = S_SHIFT;
               end
               default: begin
`ifdef BOOTH_SKIP_ADD_EN
                  // No-op iteration: shift right here instead of spending a SHIFT cycle.
                  shRA        = 1'b1;
                  shRY        = 1'b1;
                  ldYminusOne = 1'b1;
                  count_nxt   = count + 1'b1;
                  state_nxt   = (count_nxt == LAST) ? S_OUT_HI : S_CHECK;
`else
                  state_nxt = S_SHIFT;
`endif
               end
            endcase
         end
         S_SHIFT: begin
            // Y-1 captures the pre-shift Y[0] because all three strobes land on one edge.
            shRA        = 1'b1;
            shRY        = 1'b1;
            ldYminusOne = 1'b1;
            count_nxt   = count + 1'b1;
            state_nxt   = (count_nxt == LAST) ? S_OUT_HI : S_CHECK;
         end
         S_OUT_HI: begin
            selL      = 1'b1;
            state_nxt = S_OUT_LO;
         end
         S_OUT_LO: begin
            selR      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: directed bench for booth_ctrl with a behavioural Booth datapath closing the loop.
`default_nettype none

module tb_booth_ctrl;

`ifdef BOOTH_SKIP_ADD_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, start;
   logic [5:0] in_bus;
   logic [1:0] Y0YminusOne;
   logic ready, done, ldX, ldY, ldA, initA, initYminusOne, aBarS;
   logic shRA, shRY, ldYminusOne, selL, selR;

   int vectors = 0;
   int miscompares = 0;

   booth_ctrl #(.N(6)) dut (
      .clk(clk), .rst(rst), .start(start), .Y0YminusOne(Y0YminusOne),
      .ready(ready), .done(done), .ldX(ldX), .ldY(ldY), .ldA(ldA),
      .initA(initA), .initYminusOne(initYminusOne), .aBarS(aBarS),
      .shRA(shRA), .shRY(shRY), .ldYminusOne(ldYminusOne),
      .selL(selL), .selR(selR)
   );

   always #5 clk = ~clk;

   // Datapath: A carries one guard bit so the most-negative case stays exact.
   logic [6:0] A;
   logic [5:0] X, Y;
   logic       ym1;
   logic [5:0] out_bus;

   always @(posedge clk) begin
      if (ldX) X <= in_bus;
      if (ldY) Y <= in_bus;
      if (initA) A <= '0;
      if (initYminusOne) ym1 <= 1'b0;
      if (ldA) A <= aBarS ? A - {X[5], X} : A + {X[5], X};
      if (shRA) A <= {A[6], A[6:1]};
      if (shRY) Y <= {A[0], Y[5:1]};
      if (ldYminusOne) ym1 <= Y[0];
   end

   assign Y0YminusOne = {Y[0], ym1};
   assign out_bus = selL ? A[5:0] : (selR ? Y : 6'b000000);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ctrl_vec();
      return {ldX, ldY, ldA, initA, initYminusOne, aBarS,
              shRA, shRY, ldYminusOne, selL, selR, done};
   endfunction

   task automatic run_op(input string tag, input logic [5:0] x, input logic [5:0] y,
                         input logic [5:0] exp_hi, input logic [5:0] exp_lo,
                         input int n_ops, input int pulse_cyc,
                         input bit chk_abar, input logic [3:0] exp_abar);
      int exp_done, hi_cyc, lo_cyc, done_cyc, done_cnt, overlap, extra_ldx, n_ld;
      logic [5:0] hi_val, lo_val;
      logic [3:0] abar_log;
      exp_done = SKIP ? (6 + n_ops + 4) : 16;
      hi_cyc = -1; lo_cyc = -1; done_cyc = -1; done_cnt = 0;
      overlap = 0; extra_ldx = 0; n_ld = 0; abar_log = '0;
      hi_val = '0; lo_val = '0;
      @(negedge clk);
      check({tag, ".ready0"}, {31'd0, ready}, 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_bus = x;
      check({tag, ".ldX"}, {31'd0, ldX}, 32'd1);
      @(negedge clk);
      in_bus = y;
      check({tag, ".ldY"}, {31'd0, ldY}, 32'd1);
      for (int cyc = 3; cyc <= 24; cyc++) begin
         @(negedge clk);
         in_bus = 6'd0;
         start = (cyc == pulse_cyc);
         if (ldA) begin
            abar_log = {abar_log[2:0], aBarS};
            n_ld++;
         end
         if (selL) begin hi_val = out_bus; hi_cyc = cyc; end
         if (selR) begin lo_val = out_bus; lo_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (selL && selR) overlap++;
         if (ldX) extra_ldx++;
      end
      start = 1'b0;
      check({tag, ".hi"}, {26'd0, hi_val}, {26'd0, exp_hi});
      check({tag, ".lo"}, {26'd0, lo_val}, {26'd0, exp_lo});
      check({tag, ".hi_cyc"}, hi_cyc, exp_done - 1);
      check({tag, ".lo_cyc"}, lo_cyc, exp_done);
      check({tag, ".done_cyc"}, done_cyc, exp_done);
      check({tag, ".done_cnt"}, done_cnt, 32'd1);
      check({tag, ".sel_overlap"}, overlap, 32'd0);
      check({tag, ".extra_load"}, extra_ldx, 32'd0);
      check({tag, ".ready_end"}, {31'd0, ready}, 32'd1);
      if (chk_abar) begin
         check({tag, ".n_ldA"}, n_ld, 32'd4);
         check({tag, ".abar_seq"}, {28'd0, abar_log}, {28'd0, exp_abar});
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_bus = 6'd0;
      repeat (3) @(negedge clk);
      check("reset.ready", {31'd0, ready}, 32'd1);
      check("reset.ctrl", {20'd0, ctrl_vec()}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle.ready", {31'd0, ready}, 32'd1);
         check("idle.ctrl", {20'd0, ctrl_vec()}, 32'd0);
      end

      run_op("p5x3",   6'd5,        6'd3,        6'b000000, 6'b001111, 2, -1, 1'b0, 4'b0000);
      run_op("m3x5",   6'b111101,   6'd5,        6'b111111, 6'b110001, 4, -1, 1'b1, 4'b1010);
      run_op("m32sq",  6'b100000,   6'b100000,   6'b010000, 6'b000000, 1, -1, 1'b0, 4'b0000);
      run_op("zero",   6'd0,        6'b101010,   6'b000000, 6'b000000, 5, -1, 1'b0, 4'b0000);
      run_op("pulse",  6'd5,        6'd3,        6'b000000, 6'b001111, 2,  9, 1'b0, 4'b0000);

      // Abort mid-operation (SHIFT of iteration 2 in the default build).
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_bus = 6'd7;
      @(negedge clk);
      in_bus = 6'd7;
      for (int cyc = 3; cyc <= 8; cyc++) begin
         @(negedge clk);
         in_bus = 6'd0;
      end
      check("abort.busy", {31'd0, ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.ready", {31'd0, ready}, 32'd1);
      check("abort.sel", {30'd0, selL, selR}, 32'd0);
      check("abort.ctrl", {20'd0, ctrl_vec()}, 32'd0);

      run_op("p7x7",   6'd7,        6'd7,        6'b000000, 6'b110001, 2, -1, 1'b0, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
